// File: rtl/cl_uart_tx_gen2_if.sv
// FIFO read port between the control-protocol TX FIFO (master) and the UART
// transmitter (slave).
interface cl_uart_tx_gen2_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_ren;

  modport master (output fifo_empty, output fifo_dout, input fifo_ren);
  modport slave  (input fifo_empty, input fifo_dout, output fifo_ren);
endinterface

// File: rtl/cl_uart_tx_gen2.sv
// Camera Link SerTFG UART transmitter: LSB-first frames with runtime divider,
// optional parity, 1/2 stop bits, break generation and line inversion.
//   state | meaning
//   IDLE  | line high, waiting for break request or FIFO data
//   RD    | one-cycle FIFO read strobe, frame config latched
//   LATCH | FIFO word and parity captured, start bit launched
//   START | start bit (line low)
//   DATA  | data bits, LSB first
//   PAR   | parity bit
//   STOP  | one or two stop bits (line high)
//   BRK   | line low while break requested, then one high guard bit
module cl_uart_tx_gen2 #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic             clk_fix,
  input  logic             rst_fix,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             cfg_invert,
  input  logic             break_req,
  cl_uart_tx_gen2_if.slave fifo_if,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);
  localparam int IDX_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LATCH, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_l_q, div_l_d;
  logic [1:0]        par_cfg_q, par_cfg_d;
  logic              stop2_l_q, stop2_l_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_idx_q, stop_idx_d;
  logic              guard_q, guard_d;
  logic              line_q, line_d;
  logic              ren_q, ren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              last_stop;

  assign bit_end   = (cnt_q == '0);
  assign last_stop = !stop2_l_q || stop_idx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_l_d    = div_l_q;
    par_cfg_d  = par_cfg_q;
    stop2_l_d  = stop2_l_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_bit_d  = par_bit_q;
    stop_idx_d = stop_idx_q;
    guard_d    = guard_q;
    line_d     = line_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        if (baud_div != '0) begin
          if (break_req) begin
            state_d = S_BRK;
            line_d  = 1'b0;
            div_l_d = baud_div;
            guard_d = 1'b0;
          end else if (!fifo_if.fifo_empty) begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        div_l_d   = baud_div;
        par_cfg_d = cfg_parity;
        stop2_l_d = cfg_stop2;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        shift_d = fifo_if.fifo_dout;
        unique case (par_cfg_q)
          2'b01:   par_bit_d = ~^fifo_if.fifo_dout;
          2'b10:   par_bit_d = ^fifo_if.fifo_dout;
          2'b11:   par_bit_d = 1'b1;
          default: par_bit_d = 1'b0;
        endcase
        cnt_d      = div_l_q;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        line_d     = 1'b0;
        state_d    = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = div_l_q;
          line_d  = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_l_q;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            if (par_cfg_q != 2'b00) begin
              line_d  = par_bit_q;
              state_d = S_PAR;
            end else begin
              line_d  = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            line_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PAR: begin
        if (bit_end) begin
          cnt_d   = div_l_q;
          line_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        // Registered pulse must be launched one cycle early to land on the last stop cycle.
        if (last_stop && ((div_l_q == '0) ? bit_end : (cnt_q == DIV_W'(1))))
          done_d = 1'b1;
        if (bit_end) begin
          if (last_stop) begin
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
            cnt_d      = div_l_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BRK: begin
        if (!guard_q) begin
          if (!break_req) begin
            guard_d = 1'b1;
            line_d  = 1'b1;
            cnt_d   = div_l_q;
          end
        end else if (bit_end) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ren_d  = (state_d == S_RD);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_l_q    <= '0;
      par_cfg_q  <= 2'b00;
      stop2_l_q  <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      par_bit_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      guard_q    <= 1'b0;
      line_q     <= 1'b1;
      ren_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_l_q    <= div_l_d;
      par_cfg_q  <= par_cfg_d;
      stop2_l_q  <= stop2_l_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_bit_q  <= par_bit_d;
      stop_idx_q <= stop_idx_d;
      guard_q    <= guard_d;
      line_q     <= line_d;
      ren_q      <= ren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo_if.fifo_ren = ren_q;
  assign txd              = line_q ^ cfg_invert;
  assign busy             = busy_q;
  assign tx_done          = done_q;
endmodule

// File: tb/tb_cl_uart_tx_gen2.sv
// Scoreboard bench: a FIFO model pushes expected frames on each read strobe and
// a line monitor decodes txd cycle by cycle against the frame rules.
`timescale 1ns/1ps
module tb_cl_uart_tx_gen2;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  typedef bit bitq_t[$];
  typedef struct {
    int data;
    int div;
    int par;
    bit stop2;
  } frame_t;

  logic clk_fix = 1'b0;
  logic rst_fix = 1'b1;
  always #5 clk_fix = ~clk_fix;

  logic [DIV_W-1:0] baud_div;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2, cfg_invert, break_req;
  logic             txd, busy, tx_done;

  logic [DIV_W-1:0] baud_div7;
  logic [1:0]       cfg_parity7;
  logic             cfg_stop2_7, cfg_invert7, break_req7;
  logic             txd7, busy7, tx_done7;
  logic             empty7;

  cl_uart_tx_gen2_if #(.DATA_W(8)) fif ();
  cl_uart_tx_gen2_if #(.DATA_W(7)) fif7 ();

  cl_uart_tx_gen2 #(.DATA_W(8), .DIV_W(DIV_W)) dut (
    .clk_fix(clk_fix), .rst_fix(rst_fix), .baud_div(baud_div),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_invert(cfg_invert),
    .break_req(break_req), .fifo_if(fif), .txd(txd), .busy(busy), .tx_done(tx_done));

  cl_uart_tx_gen2 #(.DATA_W(7), .DIV_W(DIV_W)) dut7 (
    .clk_fix(clk_fix), .rst_fix(rst_fix), .baud_div(baud_div7),
    .cfg_parity(cfg_parity7), .cfg_stop2(cfg_stop2_7), .cfg_invert(cfg_invert7),
    .break_req(break_req7), .fifo_if(fif7), .txd(txd7), .busy(busy7), .tx_done(tx_done7));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line bit sequence of one frame, straight from the framing rules.
  function automatic bitq_t frame_bits(input int w, input int d, input int par, input bit s2);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      q.push_back(bit'((d >> i) & 1));
      ones += (d >> i) & 1;
    end
    case (par)
      1: q.push_back(ones % 2 == 0);
      2: q.push_back(ones % 2 == 1);
      3: q.push_back(1'b1);
      default: ;
    endcase
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    return q;
  endfunction

  // FIFO model: data appears the cycle after the strobe; config is bound to the word at read time.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_cnt = 0;
  frame_t exp_q[$];

  assign fif.fifo_empty  = (rd_ptr == wr_ptr);
  assign fif7.fifo_empty = empty7;
  assign fif7.fifo_dout  = 7'h41;

  always @(posedge clk_fix) begin
    if (fif.fifo_ren === 1'b1) begin
      frame_t f;
      f.data  = int'(mem[rd_ptr % 256]);
      f.div   = int'(baud_div);
      f.par   = int'(cfg_parity);
      f.stop2 = cfg_stop2;
      exp_q.push_back(f);
      fif.fifo_dout <= mem[rd_ptr % 256];
      rd_ptr  <= rd_ptr + 1;
      ren_cnt <= ren_cnt + 1;
    end
  end

  // Line monitor
  bit    in_frame = 0;
  bitq_t bq;
  int    pos = 0, hold = 0, cur_div = 0;
  int    frames_done = 0;
  bit    prev_line = 1;
  int    mcyc = 0, last_end = 0, last_gap = 0;
  bit    chk_busy = 0;

  initial begin : monitor
    frame_t f;
    logic   line;
    forever begin
      @(negedge clk_fix);
      mcyc++;
      line = txd ^ cfg_invert;
      if (rst_fix) begin
        in_frame = 0;
        chk_busy = 0;
      end else begin
        if (chk_busy) begin
          check("busy_after_done", busy, 0);
          chk_busy = 0;
        end
        if (!in_frame && prev_line && !line && exp_q.size() > 0) begin
          f        = exp_q.pop_front();
          bq       = frame_bits(DATA_W, f.data, f.par, f.stop2);
          cur_div  = f.div;
          pos      = 0;
          hold     = 0;
          in_frame = 1;
          last_gap = mcyc - last_end;
        end
        if (in_frame) begin
          check("line_bit", line, bq[pos]);
          check("busy_in_frame", busy, 1);
          check("tx_done", tx_done, (pos == bq.size() - 1 && hold == cur_div));
          hold++;
          if (hold == cur_div + 1) begin
            hold = 0;
            pos++;
            if (pos == bq.size()) begin
              in_frame = 0;
              frames_done++;
              last_end = mcyc;
              chk_busy = 1;
            end
          end
        end else begin
          check("tx_done_idle", tx_done, 0);
        end
      end
      prev_line = line;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_fix);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk_fix);
      n++;
    end
    check("frame_timeout", frames_done >= target, 1);
  endtask

  initial begin : main
    int base, ren0, n, lows, highs, nw;
    bitq_t b7;
    baud_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_invert = 1'b0; break_req = 1'b0;
    baud_div7 = 16'd1; cfg_parity7 = 2'b10; cfg_stop2_7 = 1'b1; cfg_invert7 = 1'b0; break_req7 = 1'b0;
    empty7 = 1'b1;

    tick(2);
    @(negedge clk_fix);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_ren", fif.fifo_ren, 0);
    check("rst_done", tx_done, 0);
    tick(1);
    rst_fix = 1'b0;

    // 8N1, divider 3, 0xA5
    base = frames_done; ren0 = ren_cnt;
    push_word(8'hA5);
    wait_frames(base + 1, 200);
    check("a5_ren_count", ren_cnt - ren0, 1);

    // 7E2 on the DATA_W=7 instance, divider 1, 0x41
    empty7 = 1'b0;
    n = 0;
    while (fif7.fifo_ren !== 1'b1 && n < 20) begin @(negedge clk_fix); n++; end
    check("f7_ren_seen", fif7.fifo_ren, 1);
    tick(1);
    empty7 = 1'b1;
    n = 0;
    while (txd7 !== 1'b0 && n < 50) begin @(negedge clk_fix); n++; end
    check("f7_start_found", txd7, 0);
    b7 = frame_bits(7, 'h41, 2, 1'b1);
    for (int i = 0; i < 22; i++) begin
      check("f7_line", txd7, b7[i / 2]);
      check("f7_done", tx_done7, i == 21);
      @(negedge clk_fix);
    end
    check("f7_idle_after", txd7, 1);
    tick(1);

    // Divider 0 holds off reads; frame 2 keeps its latched divider
    baud_div = 16'd0;
    base = frames_done; ren0 = ren_cnt;
    push_word(8'($urandom));
    push_word(8'($urandom));
    tick(20);
    check("div0_no_ren", ren_cnt - ren0, 0);
    baud_div = 16'd2;
    wait_frames(base + 1, 200);
    tick(6);
    baud_div = 16'd7;
    wait_frames(base + 2, 200);
    check("b2b_gap", last_gap, 4);
    check("div0_ren_count", ren_cnt - ren0, 2);

    // Break with FIFO non-empty
    tick(3);
    baud_div = 16'd4;
    base = frames_done; ren0 = ren_cnt;
    break_req = 1'b1;
    push_word(8'h3C);
    lows = 0; highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_fix);
      if (txd === 1'b0) lows++;
      tick(1);
    end
    check("brk_no_ren", ren_cnt - ren0, 0);
    break_req = 1'b0;
    n = 0;
    @(negedge clk_fix);
    while (txd === 1'b0 && n < 100) begin lows++; @(negedge clk_fix); n++; end
    while (txd === 1'b1 && n < 200) begin highs++; @(negedge clk_fix); n++; end
    check("brk_low_cycles", lows, 50);
    check("brk_guard_gap", highs, 8);
    wait_frames(base + 1, 200);

    // Reset during data bit 3
    tick(2);
    baud_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    base = frames_done;
    push_word(8'h96);
    push_word(8'h5A);
    n = 0;
    while (!(in_frame && pos == 4) && n < 200) begin @(negedge clk_fix); n++; end
    check("rst_bit3_reached", in_frame && pos == 4, 1);
    tick(1);
    rst_fix = 1'b1;
    @(posedge clk_fix);
    @(negedge clk_fix);
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ren", fif.fifo_ren, 0);
    tick(1);
    rst_fix = 1'b0;
    wait_frames(base + 1, 200);
    check("midrst_fifo_drained", rd_ptr, wr_ptr);

    // Inverted line, 0x00
    tick(2);
    cfg_invert = 1'b1;
    @(negedge clk_fix);
    check("inv_idle_txd", txd, 0);
    base = frames_done;
    tick(1);
    push_word(8'h00);
    wait_frames(base + 1, 200);
    @(negedge clk_fix);
    check("inv_idle_after", txd, 0);
    tick(1);
    cfg_invert = 1'b0;

    // Randomised batches
    for (int b = 0; b < 20; b++) begin
      tick(2);
      baud_div   = 16'($urandom_range(1, 4));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      cfg_invert = 1'($urandom_range(0, 1));
      tick(1);
      base = frames_done;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) push_word(8'($urandom));
      wait_frames(base + nw, nw * 200);
    end

    tick(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
